// File: rtl/idiv_seq.sv
// Sequential radix-2 restoring integer divider: quotient or remainder, signed or
// unsigned, 64-bit or 32-bit short mode, with flags in the multiplier's layout.
module idiv_seq #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clkEn,
  input  logic         en,
  input  logic [2:0]   op,
  input  logic [W:0]   R,
  input  logic [W:0]   C,
  output logic         busy,
  output logic         done,
  output logic [W:0]   Res,
  output logic [5:0]   flg
);

  localparam int H  = W / 2;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [W-1:0]  rem, quo, dvs;
  logic [CW-1:0] cnt;
  logic          shrt_q, rsel_q, q_neg, r_neg, skip_fix, ovf;

  function automatic logic [W-1:0] twos_neg(input logic [W-1:0] x);
    return ~x + ONE;
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Accept-time operand conditioning and special-case detection
  logic          start, shrt, sgn, a_neg, c_neg, div_zero, sovf;
  logic [W-1:0]  a_raw, c_raw, a_w, c_w, a_abs, c_abs, mask, min_val;
  logic          unused_top_bits;

  assign unused_top_bits = &{1'b0, R[W], C[W]};
  assign start   = en && ((state == IDLE) || (state == DONE));
  assign shrt    = op[2];
  assign sgn     = op[0];
  assign a_raw   = R[W-1:0];
  assign c_raw   = C[W-1:0];
  assign mask    = shrt ? {{H{1'b0}}, {H{1'b1}}} : {W{1'b1}};
  assign min_val = shrt ? {{H{1'b0}}, 1'b1, {(H-1){1'b0}}} : {1'b1, {(W-1){1'b0}}};
  assign a_w     = a_raw & mask;
  assign c_w     = c_raw & mask;
  assign a_neg   = sgn && (shrt ? a_raw[H-1] : a_raw[W-1]);
  assign c_neg   = sgn && (shrt ? c_raw[H-1] : c_raw[W-1]);
  assign a_abs   = a_neg ? (twos_neg(a_w) & mask) : a_w;
  assign c_abs   = c_neg ? (twos_neg(c_w) & mask) : c_w;
  assign div_zero = (c_w == {W{1'b0}});
  assign sovf    = sgn && (a_w == min_val) && (c_w == mask);

  // One restoring step; the difference's top bit is the borrow
  logic [W:0]   rem_sh, diff;
  logic [W-1:0] step_rem, step_quo;

  assign rem_sh   = {rem, quo[W-1]};
  assign diff     = rem_sh - {1'b0, dvs};
  assign step_rem = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
  assign step_quo = {quo[W-2:0], ~diff[W]};

  // Sign fix-up, selection and flag generation for the FIX cycle
  logic [W-1:0] q_val, r_val, res_sel, res_fix;
  logic         sf;
  logic [5:0]   flg_fix;

  always_comb begin
    q_val   = (!skip_fix && q_neg) ? twos_neg(quo) : quo;
    r_val   = (!skip_fix && r_neg) ? twos_neg(rem) : rem;
    res_sel = rsel_q ? r_val : q_val;
    if (shrt_q) begin
      res_fix = {{H{1'b0}}, res_sel[H-1:0]};
      sf      = res_sel[H-1];
    end else begin
      res_fix = res_sel;
      sf      = res_sel[W-1];
    end
    flg_fix = {1'b0, ovf, 1'b0, sf, (res_fix == {W{1'b0}}), even_parity(res_fix[7:0])};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (clkEn) begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = (div_zero || sovf) ? FIX : ITER;
        end else begin
          next_state = IDLE;
        end
      end
      ITER: begin
        if (cnt == CW'(1)) begin
          next_state = FIX;
        end else begin
          next_state = ITER;
        end
      end
      FIX:     next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ITER, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath and result registers; results hold until the next FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= {W{1'b0}};
      quo      <= {W{1'b0}};
      dvs      <= {W{1'b0}};
      cnt      <= {CW{1'b0}};
      shrt_q   <= 1'b0;
      rsel_q   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      skip_fix <= 1'b0;
      ovf      <= 1'b0;
      Res      <= {(W+1){1'b0}};
      flg      <= 6'd0;
    end else if (clkEn) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shrt_q <= shrt;
            rsel_q <= op[1];
            q_neg  <= a_neg ^ c_neg;
            r_neg  <= a_neg;
            dvs    <= c_abs;
            cnt    <= shrt ? CW'(H) : CW'(W);
            if (div_zero) begin
              quo      <= mask;
              rem      <= a_w;
              ovf      <= 1'b1;
              skip_fix <= 1'b1;
            end else if (sovf) begin
              quo      <= min_val;
              rem      <= {W{1'b0}};
              ovf      <= 1'b1;
              skip_fix <= 1'b1;
            end else begin
              // Short dividends sit in the upper half so 32 shifts consume them
              quo      <= shrt ? {a_abs[H-1:0], {H{1'b0}}} : a_abs;
              rem      <= {W{1'b0}};
              ovf      <= 1'b0;
              skip_fix <= 1'b0;
            end
          end
        end
        ITER: begin
          rem <= step_rem;
          quo <= step_quo;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          Res <= {1'b0, res_fix};
          flg <= flg_fix;
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idiv_seq.sv
// Self-checking bench for idiv_seq: a reference model fills a scoreboard at
// accept time and a monitor checks result, flags and latency on each done pulse.
module tb_idiv_seq;

  logic        clk, rst, clkEn, en;
  logic [2:0]  op;
  logic [64:0] R, C;
  logic        busy, done;
  logic [64:0] Res;
  logic [5:0]  flg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [64:0] res;
    logic [5:0]  flg;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sb[$];

  idiv_seq #(.W(64)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .en(en), .op(op),
    .R(R), .C(C), .busy(busy), .done(done), .Res(Res), .flg(flg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model written from the operation's arithmetic definition
  task automatic model(input logic [63:0] r, input logic [63:0] c, input logic [2:0] o,
                       output logic [64:0] res, output logic [5:0] f, output int lat);
    logic [63:0] q, m, out;
    logic [31:0] r32, c32;
    int          rs, cs;
    longint      rl, cl;
    logic        of, sp, sf;
    of = 1'b0; sp = 1'b0;
    r32 = r[31:0]; c32 = c[31:0]; rs = r32; cs = c32; rl = r; cl = c;
    if (o[2]) begin
      if (c32 == 32'd0) begin
        q = {32'd0, 32'hFFFF_FFFF}; m = {32'd0, r32}; of = 1'b1; sp = 1'b1;
      end else if (o[0] && r32 == 32'h8000_0000 && c32 == 32'hFFFF_FFFF) begin
        q = {32'd0, r32}; m = 64'd0; of = 1'b1; sp = 1'b1;
      end else if (o[0]) begin
        q = {32'd0, 32'(rs / cs)}; m = {32'd0, 32'(rs % cs)};
      end else begin
        q = {32'd0, r32 / c32}; m = {32'd0, r32 % c32};
      end
      out = o[1] ? m : q;
      sf  = out[31];
    end else begin
      if (c == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; m = r; of = 1'b1; sp = 1'b1;
      end else if (o[0] && r == 64'h8000_0000_0000_0000 && c == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = r; m = 64'd0; of = 1'b1; sp = 1'b1;
      end else if (o[0]) begin
        q = 64'(rl / cl); m = 64'(rl % cl);
      end else begin
        q = r / c; m = r % c;
      end
      out = o[1] ? m : q;
      sf  = out[63];
    end
    res = {1'b0, out};
    f   = {1'b0, of, 1'b0, sf, (out == 64'd0), ~^out[7:0]};
    lat = sp ? 2 : (o[2] ? 34 : 66);
  endtask

  task automatic push_after_accept(input logic [63:0] r, input logic [63:0] c, input logic [2:0] o,
                                   input int extra, input bit hold);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (!hold) en = 1'b0;
    model(r, c, o, e.res, e.flg, e.lat);
    e.lat   = e.lat + extra;
    e.t_acc = cyc;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [63:0] r, input logic [63:0] c, input logic [2:0] o,
                          input int extra, input bit hold);
    @(negedge clk);
    R  = {1'b1, r};
    C  = {1'b1, c};
    op = o;
    en = 1'b1;
    push_after_accept(r, c, o, extra, hold);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done, 1'b1);
  endtask

  // Monitor: compare each rising done against the oldest expectation
  initial begin
    logic done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !done_q) begin
        if (sb.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          check("res", Res, sb[0].res);
          check("flg", flg, sb[0].flg);
          check("latency", cyc - sb[0].t_acc + 1, sb[0].lat);
          void'(sb.pop_front());
        end
      end
      done_q = (done === 1'b1);
    end
  end

  initial begin
    rst = 1'b1; clkEn = 1'b1; en = 1'b0; op = 3'd0; R = 65'd0; C = 65'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", Res, 65'd0);
    check("rst_flg", flg, 6'd0);

    start_op(64'd100, 64'd7, 3'b000, 0, 1'b0); wait_idle();
    start_op(64'd100, 64'd7, 3'b010, 0, 1'b0); wait_idle();
    start_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 3'b011, 0, 1'b0); wait_idle();
    start_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 3'b001, 0, 1'b0); wait_idle();
    start_op(64'd5, 64'd0, 3'b000, 0, 1'b0); wait_idle();
    start_op(64'd5, 64'd0, 3'b010, 0, 1'b0); wait_idle();
    start_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 0, 1'b0); wait_idle();
    start_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 0, 1'b0); wait_idle();
    start_op(64'd0, 64'd7, 3'b000, 0, 1'b0); wait_idle();
    start_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 3'b101, 0, 1'b0); wait_idle();
    start_op(64'h1234_5678_FFFF_FF00, 64'hABCD_0000_0000_0000, 3'b111, 0, 1'b0); wait_idle();

    // en held through busy: only one accept, then a back-to-back accept in DONE
    start_op(64'h0000_0000_FFFF_FFF0, 64'd3, 3'b101, 0, 1'b1);
    wait_done();
    check("busy_in_done", busy, 1'b0);
    push_after_accept(64'h0000_0000_FFFF_FFF0, 64'd3, 3'b101, 0, 1'b0);
    wait_idle();

    // Five stalled cycles mid-ITER
    start_op(64'hFEDC_BA98_7654_3210, 64'd12345, 3'b000, 5, 1'b0);
    repeat (10) @(negedge clk);
    clkEn = 1'b0;
    repeat (5) @(negedge clk);
    clkEn = 1'b1;
    wait_idle();

    // Stall while done is pending: pulse stretches, no duplicate
    start_op(64'd9, 64'd0, 3'b000, 0, 1'b0);
    wait_done();
    clkEn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("done_held", done, 1'b1);
    end
    clkEn = 1'b1;
    @(negedge clk);
    check("done_cleared", done, 1'b0);
    wait_idle();

    // Reset mid-operation discards it
    start_op(64'd1000, 64'd3, 3'b000, 0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_res", Res, 65'd0);
    check("midrst_done", done, 1'b0);
    repeat (80) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      logic [63:0] rr, cc;
      rr = {$urandom, $urandom};
      if (i % 3 == 0)      cc = {32'd0, $urandom};
      else if (i % 3 == 1) cc = 64'($urandom_range(1, 1000));
      else                 cc = {$urandom, $urandom};
      start_op(rr, cc, 3'($urandom_range(0, 7)), 0, 1'b0);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idiv_seq.md
# idiv_seq

Sequential radix-2 integer divider for the integer execution cluster. It is the inverse-operation partner of the pipelined multiplier and shares the same operand and result bus format. One operation is accepted at a time and iterated over 32 or 64 cycles. It returns quotient or remainder, signed or unsigned, with a 6-bit flag vector in the multiplier's flag layout. Issue logic uses `busy` to keep new divides off the unit while one is in flight.

## Interface
Parameters:
- `W`, 64: full operand width; the short mode uses `W/2`.

Ports:
- `clk`, input, 1: clock. Single clock domain.
- `rst`, input, 1: reset. Synchronous, active-high.
- `clkEn`, input, 1: global stall. When low, all state, counters and outputs hold.
- `en`, input, 1: start request. Accepted only when `clkEn && !busy`.
- `op`, input, 3: operation select, sampled at accept.
  - bit0: signed.
  - bit1: return remainder (else quotient).
  - bit2: short, 32-bit.
- `R`, input, 65: dividend. Bit 64 is ignored.
- `C`, input, 65: divisor. Bit 64 is ignored.
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle pulse; `Res` and `flg` are valid.
- `Res`, output, 65: result. Bit 64 is always 0. Short results are zero-extended from bit 31.
- `flg`, output, 6: {CF, OF, 0, SF, ZF, PF}.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE, on accept:
  - Latch `op`.
  - Take absolute values of the operands when signed.
  - Record quotient sign = sign(R) ^ sign(C) and remainder sign = sign(R). In short mode, signs come from bit 31.
  - Load N = 32 (short) or 64 into `cnt`.
- Special cases are detected at accept and go directly to FIX with the result preset; ITER is skipped.
  - Divisor zero: quotient = all ones (of the width), remainder = dividend, OF = 1.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0, OF = 1.
- ITER, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem. If there is no borrow, commit the difference and set the quotient LSB to 1.
  - Decrement `cnt`. Go to FIX when `cnt` reaches 1 at the step.
- FIX:
  - Negate the quotient and/or remainder per the recorded signs (signed only).
  - Select quotient or remainder.
  - Zero-extend a short result.
  - Compute the flags.
- DONE:
  - Drive `done` = 1 for one cycle.
  - Register `Res` and `flg`, which hold until the next DONE.
  - Return to IDLE.
- Flags:
  - CF = 0 always.
  - SF = result bit 63 (bit 31 if short).
  - ZF = result == 0.
  - PF = ~^Res[7:0].
  - OF as specified in the special cases, else 0.
- `en` while busy is ignored. It is not queued.

## Timing
- Accept at edge T, in IDLE with `clkEn && en`. `busy` = 1 from T+1.
- Normal operation: ITER runs T+1..T+N, FIX at T+N+1, `done` at T+N+2.
  - Latency is 66 cycles for 64-bit and 34 cycles for 32-bit.
- Special case: FIX at T+1, `done` at T+2.
- `busy` falls in the DONE cycle. A new `en` in that same cycle is accepted, giving back-to-back throughput of N+2.
- With `clkEn` low, the state machine, `cnt` and `done` freeze. A `done` pulse that is pending is extended, not duplicated. Latency grows by the number of stalled cycles.
- Reset values (`rst` at any edge, including mid-operation):
  - state = IDLE, `busy` = 0, `done` = 0, `Res` = 0, `flg` = 0.
  - The in-flight operation is discarded and no `done` is issued.
- `rst` has priority over `clkEn`.

## Test plan
- Unsigned 64-bit quotient: R = 100, C = 7, op = 000 -> `done` at T+66, Res = 14, flg = 000000 with PF = ~^0x0E = 0. Then op = 010 -> Res = 2.
- Signed remainder: R = -100, C = 7, op = 011 -> Res = 0xFFFF_FFFF_FFFF_FFFE, SF = 1. Signed quotient (op = 001) -> Res = -14.
- Divide by zero, 64-bit: C = 0, R = 5, op = 000 -> `done` at T+2, Res = all ones, OF = 1. Remainder variant -> Res = 5.
- Signed overflow: R = 0x8000_0000_0000_0000, C = -1, op = 001 -> Res = 0x8000_0000_0000_0000, OF = 1, `done` at T+2.
- Short signed: R = 0x0000_0000_FFFF_FFF0 (-16), C = 3, op = 101 -> `done` at T+34, Res = 0x0000_0000_FFFF_FFFB. `en` held high during busy accepts nothing until the DONE cycle.
- Control disturbances:
  - `clkEn` low for 5 cycles mid-ITER -> `done` at T+71 with the correct result.
  - `rst` at T+10 -> `busy` = 0, `Res` = 0, and no `done` pulse thereafter.
